hazard_scheduler: RTL
=====================

Name: hazard_scheduler

Overview:
- Issue controller for the Fetch -> Decode -> Execute pipeline.
- Keeps a per-register scoreboard of in-flight results and stalls decode issue on read-after-write hazards.
- Sequences a multi-cycle flush when Execute reports a branch/jump mispredict.
- Produces the valid bit for the Execute stage and a saturating stall performance counter.

Parameters:
- NUM_REGS, 32: architectural registers tracked; x0 is never tracked.
- LAT_W, 2: width of the result-latency field; max latency is 2^LAT_W-1.
- FLUSH_CYCLES, 2: cycles decode_flush is held after a redirect (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- dec_valid  in  1  Decode holds a valid instruction
- dec_rs1  in  5  source register 1 (0 = unused)
- dec_rs2  in  5  source register 2 (0 = unused)
- dec_rd  in  5  destination register (0 = no write)
- dec_lat  in  LAT_W  cycles until result is forwardable; 0 = forwardable next cycle
- redirect  in  1  Execute resolved a mispredict this cycle
- dec_ready  out  1  Decode instruction is accepted this cycle (combinational)
- fetch_stall  out  1  hold Fetch and Decode flops (combinational)
- decode_flush  out  1  invalidate Fetch/Decode contents (combinational from state)
- ex_valid  out  1  registered; Execute holds a valid instruction
- busy_mask  out  NUM_REGS  bit r set when scoreboard counter for r is nonzero; bit 0 is always 0
- stall_count  out  16  saturating count of stalled cycles

Behaviour:
- Reset (async, rst=1):
  - All scoreboard counters cnt[r] = 0; state = RUN; flush counter = 0.
  - ex_valid = 0; stall_count = 0.
  - Reset mid-flush or mid-stall drops all pending state immediately.
- Hazard (combinational): hazard = dec_valid & ((rs1!=0 & cnt[rs1]!=0) | (rs2!=0 & cnt[rs2]!=0)).
  - Counters are sampled before this cycle's decrement.
- State RUN:
  - dec_ready = ~hazard.
  - issue = dec_valid & ~hazard & ~redirect.
  - fetch_stall = dec_valid & hazard.
  - decode_flush = 0.
- State FLUSH:
  - dec_ready = 0; issue = 0; fetch_stall = 0; decode_flush = 1.
- Transitions:
  - RUN -> FLUSH on redirect; flush counter loads FLUSH_CYCLES-1.
  - In FLUSH, the counter decrements each cycle; FLUSH -> RUN when counter==0 and ~redirect.
  - redirect while in FLUSH reloads the counter (flush extends).
  - Net effect: decode_flush is high for exactly FLUSH_CYCLES cycles after the last redirect.
- Redirect same cycle as a would-be issue: the instruction is killed.
  - Not issued; no scoreboard write; ex_valid next cycle = 0.
- ex_valid <= issue every cycle.
- Scoreboard update, each cycle, per register r != 0:
  - Base value: dec = (cnt[r]!=0) ? cnt[r]-1 : 0.
  - If issue & dec_rd==r & dec_lat!=0: cnt[r] <= max(dec, dec_lat) (WAW keeps the longer result pending).
  - Otherwise cnt[r] <= dec.
- Scoreboard is not cleared by redirect: issued instructions are older than the branch and still complete.
- issue with dec_lat==0 or dec_rd==0 leaves the scoreboard unchanged beyond the decrement.
- An instruction reading its own pending rd stalls like any other RAW.
- busy_mask[r] = (cnt[r]!=0); bit 0 tied 0.
- stall_count increments on each cycle with fetch_stall=1 and saturates at 16'hFFFF (no wrap).

Test Plan:
- Reset mid-flush: redirect at cycle 0, assert rst at cycle 1 -> decode_flush=0, ex_valid=0, busy_mask=0 and stall_count=0 asynchronously; RUN state after release.
- Load-use stall: issue rd=5, lat=2 at cycle 0; next instruction rs1=5 valid from cycle 1:
  - dec_ready=0 and fetch_stall=1 at cycle 1 (cnt=2).
  - Still stalled at cycle 2 (cnt=1).
  - dec_ready=1 at cycle 3.
  - stall_count=2; busy_mask[5] high for cycles 1-2.
- x0 and zero latency: rd=0 lat=3, then rd=7 lat=0, followed by reads of x0 and x7 -> no stall, busy_mask stays 0, ex_valid=1 each cycle.
- Redirect with FLUSH_CYCLES=2:
  - redirect pulse at cycle 4 with dec_valid=1 -> ex_valid=0 at cycle 5.
  - decode_flush=1 for cycles 5-6; dec_ready=1 at cycle 7.
  - A second redirect at cycle 5 extends decode_flush through cycle 7.
- WAW: issue rd=3 lat=3, then rd=3 lat=1 next cycle -> cnt[3] stays 2 (max rule); a reader of x3 stalls until cnt[3]=0.
- Counter saturation: force 70000 stall cycles (rs1 blocked by repeated lat=3 reissues) -> stall_count=16'hFFFF and holds.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Decode issue controller: per-register RAW scoreboard, mispredict flush sequencing,
// Execute valid bit and a saturating stall counter.
module hazard_scheduler #(
    parameter int NUM_REGS     = 32,
    parameter int LAT_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [4:0]          dec_rs1,
    input  logic [4:0]          dec_rs2,
    input  logic [4:0]          dec_rd,
    input  logic [LAT_W-1:0]    dec_lat,
    input  logic                redirect,
    output logic                dec_ready,
    output logic                fetch_stall,
    output logic                decode_flush,
    output logic                ex_valid,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [15:0]         stall_count
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t                              r_state;
    state_t                              w_state_next;
    logic [3:0]                          r_flush_cnt;
    logic [3:0]                          w_flush_cnt_next;
    logic [NUM_REGS-1:0][LAT_W-1:0]      r_cnt;
    logic [NUM_REGS-1:0][LAT_W-1:0]      w_cnt_next;
    logic [NUM_REGS-1:0]                 w_busy;
    logic                                r_ex_valid;
    logic [15:0]                         r_stall_count;
    logic                                w_hazard;
    logic                                w_issue;
    logic                                w_dec_ready;
    logic                                w_fetch_stall;
    logic                                w_decode_flush;

    // Scoreboard lanes; x0 is never tracked and stays permanently idle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_x0
                assign w_busy[gi]     = 1'b0;
                assign w_cnt_next[gi] = '0;
            end else begin : g_reg
                logic [LAT_W-1:0] w_dec;
                logic             w_load;
                assign w_busy[gi] = (r_cnt[gi] != '0);
                assign w_dec      = w_busy[gi] ? (r_cnt[gi] - 1'b1) : '0;
                assign w_load     = w_issue && (dec_rd == 5'(gi)) && (dec_lat != '0);
                // Overlapping writes keep whichever result finishes later.
                assign w_cnt_next[gi] = (w_load && (dec_lat > w_dec)) ? dec_lat : w_dec;
            end
        end
    endgenerate

    // Counters are sampled before this cycle's decrement.
    assign w_hazard = dec_valid &&
                      (((dec_rs1 != 5'd0) && w_busy[dec_rs1]) ||
                       ((dec_rs2 != 5'd0) && w_busy[dec_rs2]));

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_dec_ready      = 1'b0;
        w_issue          = 1'b0;
        w_fetch_stall    = 1'b0;
        w_decode_flush   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_dec_ready   = ~w_hazard;
                w_issue       = dec_valid && !w_hazard && !redirect;
                w_fetch_stall = dec_valid && w_hazard;
                if (redirect) begin
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = FLUSH_RELOAD;
                end
            end
            ST_FLUSH: begin
                w_decode_flush = 1'b1;
                if (redirect) begin
                    w_flush_cnt_next = FLUSH_RELOAD;
                end else if (r_flush_cnt == 4'd0) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_flush_cnt   <= 4'd0;
            r_cnt         <= '0;
            r_ex_valid    <= 1'b0;
            r_stall_count <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_cnt       <= w_cnt_next;
            r_ex_valid  <= w_issue;
            if (w_fetch_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign dec_ready    = w_dec_ready;
    assign fetch_stall  = w_fetch_stall;
    assign decode_flush = w_decode_flush;
    assign ex_valid     = r_ex_valid;
    assign busy_mask    = w_busy;
    assign stall_count  = r_stall_count;

endmodule
